// File: rtl/writeback_pkg.sv
// Shared types and constants for the writeback stage and its decode-side consumers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package writeback_pkg;

    localparam int XLEN  = 32;
    localparam int OP_W  = 5;
    localparam int RF_AW = 4;

    // Opcode map; only NOP, STR and JMP leave the destination register untouched.
    localparam logic [OP_W-1:0] OP_NOP = 5'd0;
    localparam logic [OP_W-1:0] OP_ADD = 5'd1;
    localparam logic [OP_W-1:0] OP_SUB = 5'd2;
    localparam logic [OP_W-1:0] OP_AND = 5'd3;
    localparam logic [OP_W-1:0] OP_OR  = 5'd4;
    localparam logic [OP_W-1:0] OP_XOR = 5'd5;
    localparam logic [OP_W-1:0] OP_SHL = 5'd6;
    localparam logic [OP_W-1:0] OP_SHR = 5'd7;
    localparam logic [OP_W-1:0] OP_LD  = 5'd8;
    localparam logic [OP_W-1:0] OP_STR = 5'd9;
    localparam logic [OP_W-1:0] OP_JMP = 5'd10;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WRITE    = 2'd1,
        WB_WAIT_MEM = 2'd2
    } wb_state_t;

    // Instruction held in the stage register between capture and retirement.
    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [RF_AW-1:0] dest;
        logic [XLEN-1:0]  result;
    } wb_stage_t;

    // True when the opcode architecturally writes its destination register.
    function automatic logic writes_rd(input logic [OP_W-1:0] op);
        return !((op == OP_NOP) || (op == OP_STR) || (op == OP_JMP));
    endfunction

endpackage

// File: rtl/writeback_regfile.sv
// 16x32 register file: one write port, two combinational read ports with write bypass.
// Latency: reads are combinational; a write becomes architectural at the next clock edge.
// Backpressure: none; a write is accepted every cycle it is enabled.
module writeback_regfile #(
    parameter int NREGS = 16,
    parameter int DW    = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [NREGS];

    // Register array: cleared on reset, r0 is an ordinary writable register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Port A read: forward the write landing at the coming edge to the same address.
    always_comb begin
        rdata_a = mem[raddr_a];
        if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
    end

    // Port B read: bypassed independently of port A.
    always_comb begin
        rdata_b = mem[raddr_b];
        if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: retires MEM results into the register file, serves decode reads.
// Latency: ALU results become architectural 1 cycle after capture; loads on mem_ack.
// Backpressure: wb_stall holds upstream while a load waits for mem_ack or times out.
module writeback
    import writeback_pkg::*;
#(
    parameter int NREGS       = 16,
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [OP_W-1:0]         in_opcode,
    input  logic [RF_AW-1:0]        in_dest,
    input  logic signed [XLEN-1:0]  in_result,
    input  logic                    in_is_load,
    input  logic                    mem_ack,
    input  logic [XLEN-1:0]         mem_rdata,
    input  logic [RF_AW-1:0]        addr_a_RF,
    input  logic [RF_AW-1:0]        addr_b_RF,
    output logic signed [XLEN-1:0]  data_a_RF,
    output logic signed [XLEN-1:0]  data_b_RF,
    output logic [RF_AW-1:0]        Daddr_fromWB,
    output logic                    wb_dest_valid,
    output logic                    wb_stall,
    output logic                    load_err,
    output logic [CNT_W-1:0]        retired
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    wb_state_t        state, state_nx;
    wb_stage_t        stage;
    logic [TO_W-1:0]  to_cnt, to_cnt_nx;
    logic             accept;
    logic             capture;
    logic             retire;
    logic             err_set;
    logic             rf_we;
    logic [XLEN-1:0]  rf_wdata;
    logic [XLEN-1:0]  rd_a, rd_b;

    // NOPs never occupy the stage, so they are neither written nor counted.
    assign accept = in_valid && (in_opcode != OP_NOP);

    // Next-state, write-port control and stage outputs.
    always_comb begin
        state_nx      = state;
        capture       = 1'b0;
        to_cnt_nx     = to_cnt;
        retire        = 1'b0;
        err_set       = 1'b0;
        rf_we         = 1'b0;
        rf_wdata      = stage.result;
        wb_stall      = 1'b0;
        wb_dest_valid = 1'b0;
        Daddr_fromWB  = '0;

        unique case (state)
            WB_IDLE: begin
                state_nx = WB_IDLE;
            end
            WB_WRITE: begin
                wb_dest_valid = writes_rd(stage.opcode);
                Daddr_fromWB  = stage.dest;
                rf_we         = writes_rd(stage.opcode);
                retire        = 1'b1;
                state_nx      = WB_IDLE;
            end
            WB_WAIT_MEM: begin
                wb_stall      = 1'b1;
                wb_dest_valid = 1'b1;
                Daddr_fromWB  = stage.dest;
                if (mem_ack) begin
                    rf_we    = 1'b1;
                    rf_wdata = mem_rdata;
                    retire   = 1'b1;
                    state_nx = WB_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    // Abandon the load: nothing written, nothing retired.
                    err_set  = 1'b1;
                    state_nx = WB_IDLE;
                end else begin
                    to_cnt_nx = to_cnt + TO_W'(1);
                end
            end
            default: begin
                state_nx = WB_IDLE;
            end
        endcase

        // A new instruction may enter on the same edge the previous one retires,
        // but never while a load is outstanding.
        if (((state == WB_IDLE) || (state == WB_WRITE)) && accept) begin
            capture   = 1'b1;
            to_cnt_nx = '0;
            state_nx  = in_is_load ? WB_WAIT_MEM : WB_WRITE;
        end
    end

    // State, stage register, timeout counter, retire counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= WB_IDLE;
            stage    <= '0;
            to_cnt   <= '0;
            retired  <= '0;
            load_err <= 1'b0;
        end else begin
            state  <= state_nx;
            to_cnt <= to_cnt_nx;
            if (capture) begin
                stage.opcode <= in_opcode;
                stage.dest   <= in_dest;
                stage.result <= in_result;
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
            if (err_set) begin
                load_err <= 1'b1;
            end
        end
    end

    writeback_regfile #(
        .NREGS (NREGS),
        .DW    (XLEN)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (stage.dest),
        .wdata   (rf_wdata),
        .raddr_a (addr_a_RF),
        .raddr_b (addr_b_RF),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    assign data_a_RF = rd_a;
    assign data_b_RF = rd_b;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios then randomized traffic.
// Latency: n/a.
// Backpressure: the bench holds in_* while wb_stall is high.
module tb_writeback;
    import writeback_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_opcode;
    logic [3:0]  in_dest;
    logic [31:0] in_result;
    logic        in_is_load;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [3:0]  addr_a_RF, addr_b_RF;
    logic [31:0] data_a_RF, data_b_RF;
    logic [3:0]  Daddr_fromWB;
    logic        wb_dest_valid, wb_stall, load_err;
    logic [31:0] retired;

    int          total = 0;
    int          bad   = 0;

    // Reference model: architectural state only.
    logic [31:0] mregs [16];
    int unsigned mret;
    logic        merr;

    logic [4:0]  rop;
    logic [3:0]  rdest;
    logic [31:0] rres, rdat, exp_a, exp_b;
    logic        rld;
    int          n, d;

    writeback #(.NREGS(16), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_opcode     (in_opcode),
        .in_dest       (in_dest),
        .in_result     (in_result),
        .in_is_load    (in_is_load),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .addr_a_RF     (addr_a_RF),
        .addr_b_RF     (addr_b_RF),
        .data_a_RF     (data_a_RF),
        .data_b_RF     (data_b_RF),
        .Daddr_fromWB  (Daddr_fromWB),
        .wb_dest_valid (wb_dest_valid),
        .wb_stall      (wb_stall),
        .load_err      (load_err),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    // Architectural rule: only NOP, STR and JMP leave rd alone.
    function automatic logic arch_writes(input logic [4:0] op);
        return !(op == OP_NOP || op == OP_STR || op == OP_JMP);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [3:0] dst,
                         input logic [31:0] res, input logic ld);
        in_valid   = v;
        in_opcode  = op;
        in_dest    = dst;
        in_result  = res;
        in_is_load = ld;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mret = 0;
        merr = 1'b0;
    endtask

    // Requires the stage idle with no instruction offered.
    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            addr_a_RF = 4'(i);
            addr_b_RF = 4'(15 - i);
            #1;
            chk({tag, "_a"}, data_a_RF, mregs[i]);
            chk({tag, "_b"}, data_b_RF, mregs[15 - i]);
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, OP_NOP, 4'd0, 32'd0, 1'b0);
        mem_ack = 1'b0; mem_rdata = '0;
        addr_a_RF = '0; addr_b_RF = '0;
        model_reset();
        #12;
        chk("rst_dvalid", wb_dest_valid, 0);
        chk("rst_stall", wb_stall, 0);
        chk("rst_err", load_err, 0);
        chk("rst_retired", retired, 0);
        chk("rst_daddr", Daddr_fromWB, 0);
        chk("rst_r0", data_a_RF, 0);
        @(negedge clk) rst = 1'b1;

        // ADD r3 = 0x42
        drive(1'b1, OP_ADD, 4'd3, 32'h42, 1'b0); addr_a_RF = 4'd3;
        tick();
        chk("add_dvalid", wb_dest_valid, 1);
        chk("add_daddr", Daddr_fromWB, 3);
        in_valid = 1'b0;
        tick();
        mregs[3] = 32'h42; mret++;
        chk("add_r3", data_a_RF, 32'h42);
        chk("add_retired", retired, mret);
        chk("add_dvalid_off", wb_dest_valid, 0);

        // Same-cycle bypass on port B
        drive(1'b1, OP_OR, 4'd5, 32'hDEAD_BEEF, 1'b0); addr_b_RF = 4'd5;
        tick();
        chk("byp_b", data_b_RF, 32'hDEAD_BEEF);
        in_valid = 1'b0;
        tick();
        mregs[5] = 32'hDEAD_BEEF; mret++;
        chk("byp_r5", data_b_RF, 32'hDEAD_BEEF);

        // Load r7, ack on the third stall cycle, ALU op held upstream meanwhile
        drive(1'b1, OP_LD, 4'd7, 32'hAAAA, 1'b1);
        tick();
        drive(1'b1, OP_ADD, 4'd8, 32'h55, 1'b0);
        addr_a_RF = 4'd7; addr_b_RF = 4'd8;
        chk("ld_daddr", Daddr_fromWB, 7);
        chk("ld_dvalid", wb_dest_valid, 1);
        for (int k = 1; k <= 3; k++) begin
            chk("ld_stall", wb_stall, 1);
            if (k == 3) begin
                mem_ack = 1'b1; mem_rdata = 32'h1234;
                #1;
                chk("ld_bypass", data_a_RF, 32'h1234);
            end
            tick();
        end
        mem_ack = 1'b0;
        mregs[7] = 32'h1234; mret++;
        chk("ld_stall_drop", wb_stall, 0);
        chk("ld_r7", data_a_RF, 32'h1234);
        chk("ld_no_capture", wb_dest_valid, 0);
        chk("ld_r8_old", data_b_RF, 0);
        tick();
        chk("ld_held_daddr", Daddr_fromWB, 8);
        in_valid = 1'b0;
        tick();
        mregs[8] = 32'h55; mret++;
        chk("ld_held_r8", data_b_RF, 32'h55);
        chk("ld_retired", retired, mret);

        // Load timeout on r2 (r2 given a known value first)
        drive(1'b1, OP_SUB, 4'd2, 32'h77, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        mregs[2] = 32'h77; mret++;
        drive(1'b1, OP_LD, 4'd2, 32'hBAD, 1'b1);
        tick();
        in_valid = 1'b0; addr_a_RF = 4'd2;
        n = 1;
        while (wb_stall === 1'b1 && n < 20) begin
            tick();
            if (wb_stall === 1'b1) n++;
        end
        merr = 1'b1;
        chk("to_stall_cycles", n, TO);
        chk("to_err", load_err, 1);
        chk("to_r2", data_a_RF, 32'h77);
        chk("to_retired", retired, mret);
        chk("to_idle", wb_dest_valid, 0);

        // STR, JMP, NOP back to back
        drive(1'b1, OP_STR, 4'd4, 32'h1111, 1'b0);
        tick();
        chk("str_dvalid", wb_dest_valid, 0);
        chk("str_daddr", Daddr_fromWB, 4);
        drive(1'b1, OP_JMP, 4'd6, 32'h2222, 1'b0);
        tick();
        chk("jmp_dvalid", wb_dest_valid, 0);
        drive(1'b1, OP_NOP, 4'd9, 32'h3333, 1'b0);
        tick();
        chk("nop_dvalid", wb_dest_valid, 0);
        in_valid = 1'b0;
        tick();
        mret += 2;
        chk("sjn_retired", retired, mret);
        check_all_regs("sjn_regs");

        // Asynchronous reset while a load is outstanding
        drive(1'b1, OP_LD, 4'd9, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0; addr_a_RF = 4'd3;
        chk("rstw_stall_pre", wb_stall, 1);
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("rstw_stall", wb_stall, 0);
        chk("rstw_dvalid", wb_dest_valid, 0);
        chk("rstw_daddr", Daddr_fromWB, 0);
        chk("rstw_err", load_err, 0);
        chk("rstw_retired", retired, 0);
        chk("rstw_r3", data_a_RF, 0);
        @(negedge clk) rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF;
        tick();
        tick();
        mem_ack = 1'b0;
        chk("rstw_late_ack", retired, 0);
        check_all_regs("rstw_regs");

        // Randomized traffic against the architectural model
        for (int i = 0; i < 250; i++) begin
            rop   = 5'($urandom_range(0, 31));
            rdest = 4'($urandom);
            rres  = $urandom;
            rld   = ($urandom_range(0, 3) == 0) && (rop != OP_NOP);
            if (rld) rop = OP_LD;
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                addr_a_RF = 4'($urandom);
                tick();
                chk("rnd_idle_read", data_a_RF, mregs[addr_a_RF]);
            end
            drive(1'b1, rop, rdest, rres, rld);
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
            addr_a_RF = 4'($urandom);
            addr_b_RF = rdest;
            tick();
            if (rop == OP_NOP) begin
                chk("rnd_nop_dvalid", wb_dest_valid, 0);
            end else if (!rld) begin
                exp_a = (arch_writes(rop) && addr_a_RF == rdest) ? rres : mregs[addr_a_RF];
                exp_b = arch_writes(rop) ? rres : mregs[rdest];
                chk("rnd_dvalid", wb_dest_valid, arch_writes(rop));
                chk("rnd_daddr", Daddr_fromWB, rdest);
                chk("rnd_read_a", data_a_RF, exp_a);
                chk("rnd_read_b", data_b_RF, exp_b);
                if (arch_writes(rop)) mregs[rdest] = rres;
                mret++;
            end else begin
                in_valid = 1'b0;
                d = $urandom_range(1, 10);
                rdat = $urandom;
                for (int k = 1; k <= TO; k++) begin
                    chk("rnd_ld_stall", wb_stall, 1);
                    if (k == d) begin
                        mem_ack = 1'b1; mem_rdata = rdat;
                        #1;
                        chk("rnd_ld_bypass", data_b_RF, rdat);
                    end else begin
                        mem_ack = 1'b0; mem_rdata = $urandom;
                    end
                    tick();
                    if (k == d) break;
                end
                mem_ack = 1'b0;
                if (d <= TO) begin
                    mregs[rdest] = rdat;
                    mret++;
                end else begin
                    merr = 1'b1;
                end
                chk("rnd_ld_done", wb_stall, 0);
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("rnd_retired", retired, mret);
        chk("rnd_err", load_err, merr);
        check_all_regs("rnd_regs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
